data_mem_responder: RTL and testbench

Memory-side responder for the CPU data-memory port: accepts one load/store request at a time over a valid/ready handshake, services it against a word-organised storage array after a programmable number of wait states, and returns a response over a second valid/ready handshake. It sits between the CPU's load/store path and the data storage. It replaces the zero-latency combinational memory so that multi-cycle and stalling CPU variants can be exercised against realistic memory latency.

---
 rtl/dmem_pkg.sv | 37 +++
 rtl/dmem_array.sv | 34 +++
 rtl/data_mem_responder.sv | 139 +++++++++++++
 tb/tb_data_mem_responder.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg : shared types and address decode for the data-memory responder
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dmem_pkg;

   localparam int LAT_W = 4;
   localparam int IDX_W = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef struct packed {
      logic             err;
      logic [IDX_W-1:0] idx;
   } dmem_dec_t;

   // depth must be a power of two; any word bits above the index range are an error
   function automatic dmem_dec_t dmem_decode(input logic [31:0] addr, input int depth);
      dmem_dec_t   d;
      logic [31:0] word;
      logic [31:0] mask;
      word  = {2'b00, addr[31:2]};
      mask  = 32'(depth - 1);
      d.idx = IDX_W'(word & mask);
      d.err = (addr[1:0] != 2'b00) || ((word & ~mask) != 32'd0);
      return d;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array : DEPTH x 32 word storage, sync write, comb read, async clear
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_array #(
   parameter int DEPTH = 128
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] idx_i,
   input  logic [31:0]              wdata_i,
   output logic [31:0]              rdata_o
);

   logic [31:0] mem_q [DEPTH];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[idx_i];

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder : valid/ready load/store responder with programmable wait states
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH   = 128,
   parameter int LATENCY = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
);

   localparam int               AW    = $clog2(DEPTH);
   localparam logic [LAT_W-1:0] LAT_C = LAT_W'(LATENCY);

   state_e             state_q, state_d;
   logic [LAT_W-1:0]   cnt_q, cnt_d;
   logic               write_q;
   logic [31:0]        addr_q, wdata_q;
   logic [31:0]        rdata_q, rdata_d;
   logic               err_q, err_d;

   logic               do_access;
   logic               acc_write;
   logic [31:0]        acc_addr, acc_wdata;
   logic [31:0]        arr_rdata;
   logic               arr_we;
   dmem_dec_t          dec;

   // With zero latency the access happens on the accepting edge, so it uses the live request
   assign acc_write = (state_q == IDLE) ? req_write_i : write_q;
   assign acc_addr  = (state_q == IDLE) ? req_addr_i  : addr_q;
   assign acc_wdata = (state_q == IDLE) ? req_wdata_i : wdata_q;
   assign dec       = dmem_decode(acc_addr, DEPTH);
   assign arr_we    = do_access && acc_write && !dec.err;

   generate
      if (AW < IDX_W) begin : g_idx_hi
         logic unused_idx_hi;
         assign unused_idx_hi = ^dec.idx[IDX_W-1:AW];
      end
   endgenerate

   dmem_array #(
      .DEPTH (DEPTH)
   ) u_array (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_i    (arr_we),
      .idx_i   (dec.idx[AW-1:0]),
      .wdata_i (acc_wdata),
      .rdata_o (arr_rdata)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      do_access   = 1'b0;
      req_ready_o = 1'b0;
      rsp_valid_o = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               if (LATENCY == 0) begin
                  do_access = 1'b1;
                  state_d   = RESP;
               end else begin
                  cnt_d   = LAT_C;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == LAT_W'(1)) begin
               do_access = 1'b1;
               cnt_d     = '0;
               state_d   = RESP;
            end else begin
               cnt_d = cnt_q - LAT_W'(1);
            end
         end
         RESP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (do_access) begin
         err_d   = dec.err;
         rdata_d = (dec.err || acc_write) ? 32'd0 : arr_rdata;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (state_q == IDLE && req_valid_i) begin
            write_q <= req_write_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
         end
      end
   end

   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder : three responders (LATENCY 2, 0, 15) on shared stimulus
// Revision              : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_data_mem_responder;

   localparam int DEPTH = 128;
   localparam int NI    = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_ready = 1'b1;

   logic        rdy   [NI];
   logic        vld   [NI];
   logic        err   [NI];
   logic [31:0] rdata [NI];

   int cyc = 0;
   int errors = 0;
   int checks = 0;

   function automatic int lat_of(input int k);
      case (k)
         0:       return 2;
         1:       return 0;
         default: return 15;
      endcase
   endfunction

   data_mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut0 (
      .clk_i(clk), .rst_i(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy[0]),
      .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .rsp_valid_o(vld[0]), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rdata[0]), .rsp_err_o(err[0]));

   data_mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_dut1 (
      .clk_i(clk), .rst_i(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy[1]),
      .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .rsp_valid_o(vld[1]), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rdata[1]), .rsp_err_o(err[1]));

   data_mem_responder #(.DEPTH(DEPTH), .LATENCY(15)) u_dut2 (
      .clk_i(clk), .rst_i(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy[2]),
      .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .rsp_valid_o(vld[2]), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rdata[2]), .rsp_err_o(err[2]));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s inst=%0d got=%h exp=%h t=%0t", nm, k, got, exp, $time);
      end
   endtask

   // Reference: a request is busy from accept to handshake, its response shows up
   // LATENCY edges after the accepting edge, and the word store lands at that edge.
   logic        m_busy [NI];
   logic        m_valid[NI];
   logic        m_err  [NI];
   logic        m_pw   [NI];
   logic [31:0] m_rdata[NI];
   logic [31:0] m_pdata[NI];
   int          m_pidx [NI];
   int          m_due  [NI];
   logic [31:0] m_mem  [NI][DEPTH];

   function automatic logic m_bad(input logic [31:0] a);
      return (a % 4 != 0) || (a >= 32'(4 * DEPTH));
   endfunction

   function automatic int m_word(input logic [31:0] a);
      return int'((a / 4) % DEPTH);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NI; k++) begin
            m_busy[k]  <= 1'b0;
            m_valid[k] <= 1'b0;
            m_err[k]   <= 1'b0;
            m_pw[k]    <= 1'b0;
            m_rdata[k] <= '0;
            m_pdata[k] <= '0;
            m_pidx[k]  <= 0;
            m_due[k]   <= 0;
            for (int i = 0; i < DEPTH; i++) m_mem[k][i] <= '0;
         end
      end else begin
         for (int k = 0; k < NI; k++) begin
            if (!m_busy[k]) begin
               if (req_valid) begin
                  m_busy[k]  <= 1'b1;
                  m_due[k]   <= cyc + lat_of(k);
                  m_err[k]   <= m_bad(req_addr);
                  m_rdata[k] <= (m_bad(req_addr) || req_write) ? 32'd0 : m_mem[k][m_word(req_addr)];
                  m_pw[k]    <= req_write && !m_bad(req_addr);
                  m_pidx[k]  <= m_word(req_addr);
                  m_pdata[k] <= req_wdata;
                  if (lat_of(k) == 0) begin
                     m_valid[k] <= 1'b1;
                     if (req_write && !m_bad(req_addr)) m_mem[k][m_word(req_addr)] <= req_wdata;
                  end
               end
            end else if (!m_valid[k]) begin
               if (cyc == m_due[k]) begin
                  m_valid[k] <= 1'b1;
                  if (m_pw[k]) m_mem[k][m_pidx[k]] <= m_pdata[k];
               end
            end else if (rsp_ready) begin
               m_valid[k] <= 1'b0;
               m_busy[k]  <= 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < NI; k++) begin
            check("model_ready", k, 32'(rdy[k]), 32'(!m_busy[k]));
            check("model_valid", k, 32'(vld[k]), 32'(m_valid[k]));
            if (m_valid[k]) begin
               check("model_rdata", k, rdata[k], m_rdata[k]);
               check("model_err", k, 32'(err[k]), 32'(m_err[k]));
            end
         end
      end
   end

   int          lat_r  [NI];
   int          per_r  [NI];
   logic [31:0] cap_rd [NI];
   logic        cap_err[NI];

   task automatic wait_all_ready();
      int t;
      t = 0;
      while (!(rdy[0] && rdy[1] && rdy[2]) && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("ready_timeout", 0, 32'(t < 50), 32'd1);
   endtask

   // One request broadcast to all instances; records first-valid and ready-again cycles.
   task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d);
      bit seen[NI];
      bit done[NI];
      bit all;
      int acc;
      wait_all_ready();
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      acc = cyc;
      for (int k = 0; k < NI; k++) begin
         seen[k] = 1'b0;
         done[k] = 1'b0;
      end
      all = 1'b0;
      for (int t = 0; t < 40 && !all; t++) begin
         @(negedge clk);
         if (t == 0) begin
            req_valid = 1'b0;
            req_write = !w;
            req_addr  = 32'hFFFF_FFFF;
            req_wdata = ~d;
         end
         all = 1'b1;
         for (int k = 0; k < NI; k++) begin
            if (!seen[k] && vld[k]) begin
               seen[k]    = 1'b1;
               lat_r[k]   = cyc - acc;
               cap_rd[k]  = rdata[k];
               cap_err[k] = err[k];
            end
            if (seen[k] && !done[k] && rdy[k]) begin
               done[k]  = 1'b1;
               per_r[k] = cyc - acc;
            end
            all &= done[k];
         end
      end
      check("xact_timeout", 0, 32'(all), 32'd1);
   endtask

   task automatic expect_rsp(input string nm, input logic [31:0] exp_rd, input logic exp_err);
      for (int k = 0; k < NI; k++) begin
         check({nm, "_rdata"}, k, cap_rd[k], exp_rd);
         check({nm, "_err"}, k, 32'(cap_err[k]), 32'(exp_err));
      end
   endtask

   initial begin
      int t;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         check("rst_ready", k, 32'(rdy[k]), 32'd1);
         check("rst_valid", k, 32'(vld[k]), 32'd0);
         check("rst_rdata", k, rdata[k], 32'd0);
         check("rst_err", k, 32'(err[k]), 32'd0);
      end

      xact(1'b0, 32'h0000_0010, 32'd0);
      expect_rsp("load_fresh", 32'd0, 1'b0);
      check("lat_L2", 0, 32'(lat_r[0]), 32'd3);
      check("lat_L0", 1, 32'(lat_r[1]), 32'd1);
      check("lat_L15", 2, 32'(lat_r[2]), 32'd16);
      check("period_L2", 0, 32'(per_r[0]), 32'd4);
      check("period_L0", 1, 32'(per_r[1]), 32'd2);
      check("period_L15", 2, 32'(per_r[2]), 32'd17);

      xact(1'b1, 32'h0000_001C, 32'hDEAD_BEEF);
      expect_rsp("store", 32'd0, 1'b0);
      xact(1'b0, 32'h0000_001C, 32'd0);
      expect_rsp("load_back", 32'hDEAD_BEEF, 1'b0);

      xact(1'b0, 32'h0000_0006, 32'd0);
      expect_rsp("misalign", 32'd0, 1'b1);
      xact(1'b1, 32'h0000_0200, 32'hCAFE_F00D);
      expect_rsp("range_store", 32'd0, 1'b1);
      xact(1'b0, 32'h0000_0000, 32'd0);
      expect_rsp("word0", 32'd0, 1'b0);
      xact(1'b1, 32'h0000_01FC, 32'h1111_1111);
      expect_rsp("top_store", 32'd0, 1'b0);
      xact(1'b0, 32'h0000_01FC, 32'd0);
      expect_rsp("top_load", 32'h1111_1111, 1'b0);

      // backpressure: responses held while the requester keeps changing its inputs
      rsp_ready = 1'b0;
      wait_all_ready();
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'h0000_001C;
      @(negedge clk);
      req_valid = 1'b0;
      t = 0;
      while (!(vld[0] && vld[1] && vld[2]) && t < 40) begin
         @(negedge clk);
         t++;
      end
      check("bp_valid_timeout", 0, 32'(t < 40), 32'd1);
      for (int i = 0; i < 5; i++) begin
         req_valid = (i % 2 == 0);
         req_write = (i % 2 == 1);
         req_addr  = 32'h40 * i;
         @(negedge clk);
         for (int k = 0; k < NI; k++) begin
            check("bp_valid", k, 32'(vld[k]), 32'd1);
            check("bp_ready", k, 32'(rdy[k]), 32'd0);
            check("bp_rdata", k, rdata[k], 32'hDEAD_BEEF);
            check("bp_err", k, 32'(err[k]), 32'd0);
         end
      end
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'h0000_0010;
      rsp_ready = 1'b1;
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         check("bp_release_valid", k, 32'(vld[k]), 32'd0);
         check("bp_release_ready", k, 32'(rdy[k]), 32'd1);
      end
      @(negedge clk);
      for (int k = 0; k < NI; k++) check("bp_resume_accept", k, 32'(rdy[k]), 32'd0);
      req_valid = 1'b0;
      wait_all_ready();

      // reset while a store is still waiting
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h0000_0004;
      req_wdata = 32'h1234_5678;
      @(negedge clk);
      req_valid = 1'b0;
      rst_n     = 1'b0;
      @(negedge clk);
      for (int k = 0; k < NI; k++) check("in_reset_valid", k, 32'(vld[k]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("post_reset_quiet", 2, 32'(vld[0] | vld[1] | vld[2]), 32'd0);
      end
      xact(1'b0, 32'h0000_0004, 32'd0);
      expect_rsp("dropped_store", 32'd0, 1'b0);
      xact(1'b0, 32'h0000_001C, 32'd0);
      expect_rsp("cleared_word", 32'd0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
